// File: rtl/aes_gcm_pkt_framer_if.sv
// Bus bundle between the packet source, the framer and the gcm_aes engine lanes.
// The master side drives packet words and the engine return path; the slave side is the framer.
interface aes_gcm_pkt_framer_if #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned BYPASS_W = 289
);
  logic                    i_new;
  logic                    i_last;
  logic [128*LANES-1:0]    i_plain_text;
  logic [BYPASS_W-1:0]     i_bypass_text;
  logic                    o_eng_new;
  logic                    o_eng_last;
  logic [128*LANES-1:0]    o_eng_text;
  logic [127:0]            o_eng_size;
  logic                    i_eng_ready;
  logic [128*LANES-1:0]    i_eng_cipher;
  logic                    o_cp_ready;
  logic [128*LANES-1:0]    o_cipher_text;
  logic [BYPASS_W-1:0]     o_bypass_text;
  logic                    o_first;
  logic                    o_len_err;

  modport master (
    output i_new, i_last, i_plain_text, i_bypass_text, i_eng_ready, i_eng_cipher,
    input  o_eng_new, o_eng_last, o_eng_text, o_eng_size,
           o_cp_ready, o_cipher_text, o_bypass_text, o_first, o_len_err
  );

  modport slave (
    input  i_new, i_last, i_plain_text, i_bypass_text, i_eng_ready, i_eng_cipher,
    output o_eng_new, o_eng_last, o_eng_text, o_eng_size,
           o_cp_ready, o_cipher_text, o_bypass_text, o_first, o_len_err
  );
endinterface

// File: rtl/aes_gcm_pkt_framer.sv
// Packet framing front end for LANES gcm_aes engines: tracks packet boundaries, derives and
// checks the GCM plaintext size, and realigns the bypass sideband with the engine cipher output.
module aes_gcm_pkt_framer #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned BYPASS_W  = 289,
  parameter int unsigned LEN_LSB   = 33,
  parameter int unsigned HDR_BYTES = 14,
  parameter int unsigned LATENCY   = 16
) (
  input  logic              clk,
  input  logic              rst,
  aes_gcm_pkt_framer_if.slave bus
);

  localparam int unsigned WORD_BITS = 128 * LANES;

  typedef enum logic [2:0] {
    ST_FIRST  = 3'b001,
    ST_SECOND = 3'b010,
    ST_INNER  = 3'b100
  } state_e;

  state_e               state_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [18:0]          size_q, size_d, cur_size;
  logic                 len_err_q, len_err_d;
  logic                 first_word;
  logic [15:0]          len_w, len_diff;
  logic [19:0]          words_num, words_exp;

  logic [BYPASS_W:0]    dly_q [LATENCY];
  logic                 cp_ready_q;
  logic [WORD_BITS-1:0] cipher_q;
  logic [BYPASS_W-1:0]  bypass_q;
  logic                 first_q;

  assign first_word = (state_q == ST_FIRST);
  assign len_w      = bus.i_bypass_text[LEN_LSB +: 16];
  assign len_diff   = len_w - 16'(HDR_BYTES);

  always_comb begin
    size_d    = '0;
    cnt_d     = cnt_q;
    words_num = '0;
    words_exp = '0;
    len_err_d = 1'b0;
    if (len_w >= 16'(HDR_BYTES)) begin
      size_d = {len_diff, 3'b000};
    end
    cur_size = (first_word && bus.i_new) ? size_d : size_q;
    // Expected word count is ceil(size / WORD_BITS), never less than one word
    words_num = {1'b0, cur_size} + 20'(WORD_BITS - 1);
    words_exp = words_num / 20'(WORD_BITS);
    if (words_exp == '0) begin
      words_exp = 20'd1;
    end
    if (first_word) begin
      cnt_d = 16'd1;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 16'd1;
    end
    len_err_d = bus.i_new && bus.i_last && ({4'b0000, cnt_d} != words_exp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FIRST;
      cnt_q     <= '0;
      size_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= len_err_d;
      if (bus.i_new) begin
        cnt_q <= cnt_d;
      end
      if (bus.i_new && first_word) begin
        size_q <= size_d;
      end
      case (state_q)
        ST_FIRST: begin
          if (bus.i_new && !bus.i_last) begin
            state_q <= ST_SECOND;
          end
        end
        ST_SECOND, ST_INNER: begin
          if (bus.i_new) begin
            state_q <= bus.i_last ? ST_FIRST : ST_INNER;
          end
        end
        default: state_q <= ST_FIRST;
      endcase
    end
  end

  // Sideband and first-word flag ride a free-running delay line matching engine latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        dly_q[k] <= '0;
      end
      cp_ready_q <= 1'b0;
      cipher_q   <= '0;
      bypass_q   <= '0;
      first_q    <= 1'b0;
    end else begin
      dly_q[0] <= {bus.i_bypass_text, bus.i_new && first_word};
      for (int unsigned k = 1; k < LATENCY; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
      cp_ready_q <= bus.i_eng_ready;
      if (bus.i_eng_ready) begin
        cipher_q <= bus.i_eng_cipher;
        bypass_q <= dly_q[LATENCY-1][BYPASS_W:1];
        first_q  <= dly_q[LATENCY-1][0];
      end
    end
  end

  assign bus.o_eng_new     = bus.i_new;
  assign bus.o_eng_last    = bus.i_new && bus.i_last;
  assign bus.o_eng_text    = bus.i_plain_text;
  assign bus.o_eng_size    = {109'b0, cur_size};
  assign bus.o_cp_ready    = cp_ready_q;
  assign bus.o_cipher_text = cipher_q;
  assign bus.o_bypass_text = bypass_q;
  assign bus.o_first       = first_q;
  assign bus.o_len_err     = len_err_q;

endmodule
